// File: rtl/rx_adc_frontend_pkg.sv
// rx_adc_frontend shared definitions.
// Settings addresses, mux source codes, saturating subtract.
package rx_adc_frontend_pkg;

  localparam logic [6:0] MUX_ADDR  = 7'd8;
  localparam logic [6:0] OFS0_ADDR = 7'd10;
  localparam logic [6:0] OFS1_ADDR = 7'd11;

  typedef enum logic [1:0] {
    SRC_A  = 2'd0,
    SRC_B  = 2'd1,
    SRC_Z0 = 2'd2,
    SRC_Z1 = 2'd3
  } mux_src_e;

  function automatic logic [15:0] sat_sub16(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15])
      return d[16] ? 16'h8000 : 16'h7FFF;
    return d[15:0];
  endfunction

endpackage

// File: rtl/rx_adc_frontend_if.sv
// Serial settings bus shared by all register blocks.
// Master drives a one-cycle strobe with address and data.
interface rx_adc_frontend_if;

  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;

  modport master (
    output serial_strobe,
    output serial_addr,
    output serial_data
  );

  modport slave (
    input serial_strobe,
    input serial_addr,
    input serial_data
  );

endinterface

// File: rtl/rx_dc_offset.sv
// Per-channel DC offset: settings register, left-justify,
// saturating subtract, registered result (stage 2).
module rx_dc_offset
  import rx_adc_frontend_pkg::*;
#(
  parameter int         ADC_W = 12,
  parameter logic [6:0] ADDR  = OFS0_ADDR
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  rx_adc_frontend_if.slave   sbus,
  input  logic [ADC_W-1:0]   adc,
  output logic [15:0]        dout
);

  logic [15:0] ofs;
  logic [15:0] ext;
  logic        wr;

  assign ext = {adc, {(16-ADC_W){1'b0}}};
  assign wr  = sbus.serial_strobe &&
               (sbus.serial_addr == ADDR);

  // offset register and stage-2 subtract; old offset used on write edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ofs  <= '0;
      dout <= '0;
    end else begin
      if (wr)
        ofs <= sbus.serial_data[15:0];
      dout <= enable ? sat_sub16(ext, ofs) : '0;
    end
  end

endmodule

// File: rtl/rx_adc_frontend.sv
// Dual-ADC receive front end: sample, DC offset, I/Q mux,
// RSSI leaky average and overload counter.
module rx_adc_frontend #(
  parameter int         ADC_W     = 12,
  parameter logic [6:0] MUX_ADDR  = rx_adc_frontend_pkg::MUX_ADDR,
  parameter logic [6:0] OFS0_ADDR = rx_adc_frontend_pkg::OFS0_ADDR,
  parameter logic [6:0] OFS1_ADDR = rx_adc_frontend_pkg::OFS1_ADDR
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  rx_adc_frontend_if.slave   sbus,
  input  logic [ADC_W-1:0]   rx_a_a,
  input  logic [ADC_W-1:0]   rx_b_a,
  output logic [15:0]        ddc0_in_i,
  output logic [15:0]        ddc0_in_q,
  output logic [3:0]         rx_numchan,
  output logic [31:0]        rssi_0
);

  logic [ADC_W-1:0] a1, b1;
  logic [15:0]      ch_a, ch_b;
  logic [7:0]       mux;
  logic [25:0]      acc;
  logic [15:0]      ovf;
  logic [15:0]      ext_a, mag_a;
  logic [15:0]      i_nxt, q_nxt;
  logic             mux_wr, ofs0_wr, ovf_hit;
  logic             unused_data;

  assign unused_data = ^sbus.serial_data[31:16];

  assign mux_wr  = sbus.serial_strobe &&
                   (sbus.serial_addr == MUX_ADDR);
  assign ofs0_wr = sbus.serial_strobe &&
                   (sbus.serial_addr == OFS0_ADDR);

  // stage 1 samples continuously, even when disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a1 <= '0;
      b1 <= '0;
    end else begin
      a1 <= rx_a_a;
      b1 <= rx_b_a;
    end
  end

  rx_dc_offset #(.ADC_W(ADC_W), .ADDR(OFS0_ADDR)) u_ofs_a (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .sbus    (sbus),
    .adc     (a1),
    .dout    (ch_a)
  );

  rx_dc_offset #(.ADC_W(ADC_W), .ADDR(OFS1_ADDR)) u_ofs_b (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .sbus    (sbus),
    .adc     (b1),
    .dout    (ch_b)
  );

  // mux settings register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      mux <= '0;
    else if (mux_wr)
      mux <= sbus.serial_data[7:0];
  end

  assign rx_numchan = mux[3:0];

  // source select for I and Q; codes 2/3 force zero
  always_comb begin
    i_nxt = '0;
    q_nxt = '0;
    unique case (rx_adc_frontend_pkg::mux_src_e'(mux[5:4]))
      rx_adc_frontend_pkg::SRC_A: i_nxt = ch_a;
      rx_adc_frontend_pkg::SRC_B: i_nxt = ch_b;
      default:                    i_nxt = '0;
    endcase
    unique case (rx_adc_frontend_pkg::mux_src_e'(mux[7:6]))
      rx_adc_frontend_pkg::SRC_A: q_nxt = ch_a;
      rx_adc_frontend_pkg::SRC_B: q_nxt = ch_b;
      default:                    q_nxt = '0;
    endcase
  end

  // stage 3 output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ddc0_in_i <= '0;
      ddc0_in_q <= '0;
    end else begin
      ddc0_in_i <= enable ? i_nxt : '0;
      ddc0_in_q <= enable ? q_nxt : '0;
    end
  end

  // magnitude of left-justified A sample; most-negative clamps
  always_comb begin
    ext_a = {a1, {(16-ADC_W){1'b0}}};
    mag_a = ext_a;
    if (ext_a == 16'h8000)
      mag_a = 16'h7FFF;
    else if (ext_a[15])
      mag_a = ~ext_a + 16'd1;
  end

  assign ovf_hit = (a1 == {1'b0, {(ADC_W-1){1'b1}}}) ||
                   (a1 == {1'b1, {(ADC_W-1){1'b0}}});

  // leaky average and saturating overload count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      ovf <= '0;
    end else begin
      if (enable)
        acc <= acc + {10'd0, mag_a} - {10'd0, acc[25:10]};
      if (ofs0_wr)
        ovf <= '0;
      else if (enable && ovf_hit && ovf != 16'hFFFF)
        ovf <= ovf + 16'd1;
    end
  end

  assign rssi_0 = {ovf, acc[25:10]};

endmodule

// File: tb/tb_rx_adc_frontend.sv
// Directed bench for rx_adc_frontend.
// Hand-computed vectors, one task per scenario.
module tb_rx_adc_frontend;
  import rx_adc_frontend_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [11:0] rx_a_a, rx_b_a;
  logic [15:0] ddc0_in_i, ddc0_in_q;
  logic [3:0]  rx_numchan;
  logic [31:0] rssi_0;
  int          checks;
  int          errors;

  rx_adc_frontend_if sbus ();

  rx_adc_frontend dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .sbus       (sbus),
    .rx_a_a     (rx_a_a),
    .rx_b_a     (rx_b_a),
    .ddc0_in_i  (ddc0_in_i),
    .ddc0_in_q  (ddc0_in_q),
    .rx_numchan (rx_numchan),
    .rssi_0     (rssi_0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    sbus.serial_strobe = 1'b1;
    sbus.serial_addr   = a;
    sbus.serial_data   = d;
    tick(1);
    sbus.serial_strobe = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    rx_a_a = 12'h155;
    rx_b_a = 12'h2AA;
    enable = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    checks++;
    if ({ddc0_in_i, ddc0_in_q} !== 32'h0) begin
      errors++;
      $display("FAIL reset_ddc got %h want 0",
               {ddc0_in_i, ddc0_in_q});
    end
    checks++;
    if ({rx_numchan, rssi_0} !== 36'h0) begin
      errors++;
      $display("FAIL reset_stat got %h want 0",
               {rx_numchan, rssi_0});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_passthrough();
    apply_reset();
    enable = 1'b1;
    rx_a_a = 12'h000;
    rx_b_a = 12'h000;
    tick(3);
    rx_a_a = 12'h100;
    tick(2);
    checks++;
    if (ddc0_in_i !== 16'h0000) begin
      errors++;
      $display("FAIL latency_early got %h want 0000",
               ddc0_in_i);
    end
    tick(1);
    checks++;
    if (ddc0_in_i !== 16'h1000 || ddc0_in_q !== 16'h1000) begin
      errors++;
      $display("FAIL pass got %h/%h want 1000/1000",
               ddc0_in_i, ddc0_in_q);
    end
    checks++;
    if (rx_numchan !== 4'd0) begin
      errors++;
      $display("FAIL numchan0 got %0d want 0", rx_numchan);
    end
  endtask

  task automatic test_offset();
    rx_a_a = 12'h100;
    wr(OFS0_ADDR, 32'h0000_0800);
    checks++;
    if (ddc0_in_i !== 16'h1000) begin
      errors++;
      $display("FAIL ofs_old got %h want 1000", ddc0_in_i);
    end
    tick(3);
    checks++;
    if (ddc0_in_i !== 16'h0800 || ddc0_in_q !== 16'h0800) begin
      errors++;
      $display("FAIL ofs got %h/%h want 0800/0800",
               ddc0_in_i, ddc0_in_q);
    end
  endtask

  task automatic test_saturation();
    rx_a_a = 12'h800;
    wr(OFS0_ADDR, 32'h0000_0010);
    tick(3);
    checks++;
    if (ddc0_in_i !== 16'h8000) begin
      errors++;
      $display("FAIL sat_neg got %h want 8000", ddc0_in_i);
    end
    rx_a_a = 12'h7FF;
    wr(OFS0_ADDR, 32'hABCD_FFF0);
    tick(3);
    checks++;
    if (ddc0_in_i !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_pos got %h want 7fff", ddc0_in_i);
    end
  endtask

  task automatic test_mux();
    rx_a_a = 12'h001;
    rx_b_a = 12'h002;
    wr(MUX_ADDR, 32'h0000_00D2);
    checks++;
    if (rx_numchan !== 4'd2) begin
      errors++;
      $display("FAIL numchan got %0d want 2", rx_numchan);
    end
    tick(3);
    checks++;
    if (ddc0_in_i !== 16'h0020 || ddc0_in_q !== 16'h0000) begin
      errors++;
      $display("FAIL mux got %h/%h want 0020/0000",
               ddc0_in_i, ddc0_in_q);
    end
  endtask

  task automatic test_rssi();
    enable = 1'b1;
    rx_a_a = 12'h7FF;
    rx_b_a = 12'h000;
    apply_reset();
    tick(1);
    checks++;
    if (rssi_0 !== 32'h0000_0000) begin
      errors++;
      $display("FAIL rssi_e1 got %h want 00000000", rssi_0);
    end
    tick(1);
    checks++;
    if (rssi_0 !== 32'h0001_001F) begin
      errors++;
      $display("FAIL rssi_e2 got %h want 0001001f", rssi_0);
    end
    tick(1);
    checks++;
    if (rssi_0 !== 32'h0002_003F) begin
      errors++;
      $display("FAIL rssi_e3 got %h want 0002003f", rssi_0);
    end
    tick(3);
    checks++;
    if (rssi_0[31:16] !== 16'd5) begin
      errors++;
      $display("FAIL ovf5 got %0d want 5", rssi_0[31:16]);
    end
    rx_a_a = 12'h000;
    wr(OFS0_ADDR, 32'h0);
    checks++;
    if (rssi_0[31:16] !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clr got %0d want 0", rssi_0[31:16]);
    end
    tick(1);
    checks++;
    if (rssi_0[31:16] !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clr2 got %0d want 0", rssi_0[31:16]);
    end
  endtask

  task automatic test_enable();
    enable = 1'b1;
    rx_a_a = 12'h7FF;
    apply_reset();
    tick(3);
    checks++;
    if (ddc0_in_i !== 16'h7FF0 || rssi_0 !== 32'h0002_003F) begin
      errors++;
      $display("FAIL en_pre got %h %h want 7ff0 0002003f",
               ddc0_in_i, rssi_0);
    end
    enable = 1'b0;
    tick(1);
    checks++;
    if (ddc0_in_i !== 16'h0 || ddc0_in_q !== 16'h0) begin
      errors++;
      $display("FAIL en_off got %h/%h want 0/0",
               ddc0_in_i, ddc0_in_q);
    end
    tick(3);
    checks++;
    if (rssi_0 !== 32'h0002_003F) begin
      errors++;
      $display("FAIL en_frz got %h want 0002003f", rssi_0);
    end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    apply_reset();
    rx_a_a = 12'h200;
    rx_b_a = 12'h003;
    wr(OFS0_ADDR, 32'h0000_0100);
    wr(MUX_ADDR, 32'h0000_0041);
    tick(3);
    checks++;
    if (ddc0_in_i !== 16'h1F00 || ddc0_in_q !== 16'h0030 ||
        rx_numchan !== 4'd1) begin
      errors++;
      $display("FAIL pre_rst got %h/%h/%0d want 1f00/0030/1",
               ddc0_in_i, ddc0_in_q, rx_numchan);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ddc0_in_i, ddc0_in_q, rx_numchan, rssi_0} !== 68'h0) begin
      errors++;
      $display("FAIL async_rst got %h want 0",
               {ddc0_in_i, ddc0_in_q, rx_numchan, rssi_0});
    end
    #1;
    reset_n = 1'b1;
    tick(3);
    checks++;
    if (ddc0_in_i !== 16'h2000 || ddc0_in_q !== 16'h2000 ||
        rx_numchan !== 4'd0) begin
      errors++;
      $display("FAIL post_rst got %h/%h/%0d want 2000/2000/0",
               ddc0_in_i, ddc0_in_q, rx_numchan);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b1;
    enable = 1'b0;
    rx_a_a = '0;
    rx_b_a = '0;
    sbus.serial_strobe = 1'b0;
    sbus.serial_addr = '0;
    sbus.serial_data = '0;
    test_reset();
    test_passthrough();
    test_offset();
    test_saturation();
    test_mux();
    test_rssi();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_adc_frontend.md
Name: rx_adc_frontend

Overview:
Receive-side ADC conditioning block between the raw dual-ADC pins and the first DDC. It registers two 12-bit ADC streams and left-justifies them to 16 bits. It then applies per-channel programmable DC-offset subtraction with saturation and routes the channels through a programmable I/Q mux into the DDC. It also produces a 32-bit RSSI/overload status word for serial readback, and all control comes from the shared serial settings bus.

Parameters:
ADC_W, 12, ADC sample width.
MUX_ADDR, 8, settings address of RX mux register.
OFS0_ADDR, 10, settings address of ADC A offset register.
OFS1_ADDR, 11, settings address of ADC B offset register.

Ports:
clock  in  1  ADC sample clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  processing enable.
serial_strobe  in  1  one-cycle settings write strobe.
serial_addr  in  7  settings address.
serial_data  in  32  settings data.
rx_a_a  in  12  ADC A sample, two's complement.
rx_b_a  in  12  ADC B sample, two's complement.
ddc0_in_i  out  16  DDC I input.
ddc0_in_q  out  16  DDC Q input.
rx_numchan  out  4  channel count for rx buffer.
rssi_0  out  32  status word for readback.

Behaviour:
- Reset, asynchronous on reset_n low: all registers clear. This gives mux=0, offsets=0, ddc0_in_i/q=0, rx_numchan=0, rssi_0=0.
- Settings writes:
  - Take effect on the edge where serial_strobe=1 and serial_addr matches the register address.
  - The new value is used from the next cycle.
  - The mux register stores serial_data[7:0].
  - The offset registers store serial_data[15:0] as a signed value.
  - Writes are accepted regardless of enable.
- Pipeline: 3 cycles from ADC pins to ddc0_in_*.
  - Stage 1 registers rx_a_a and rx_b_a.
  - Stage 2 computes ext = {adc, 4'b0000}, then d = ext − offset in 17-bit signed arithmetic. The result saturates to 16 bits, clamping to [0x8000, 0x7FFF], and is registered.
  - Stage 3 is the mux output register.
- Mux:
  - rx_numchan = mux[3:0], combinational from the register.
  - I source = mux[5:4] and Q source = mux[7:6]. Encoding: 0 = channel A, 1 = channel B, 2 or 3 = constant 0.
- enable low:
  - Stages 2 and 3 load 0, so ddc0_in_i/q go to 0 from the next edge.
  - rssi_0 holds its value.
  - Stage 1 keeps sampling.
- RSSI, computed on the stage-1 ADC A sample when enable is high:
  - Lower field, rssi_0[15:0]: leaky average of the magnitude, acc(26-bit) += |ext_a| − (acc >> 10), and rssi_0[15:0] = acc[25:10]. |0x8000| is treated as 0x7FFF.
  - Overload field, rssi_0[31:16]: increments each cycle the raw ADC A sample equals 12'h7FF or 12'h800. It saturates at 0xFFFF with no wrap, is registered, and is cleared by any write to OFS0_ADDR.
- Simultaneous settings write and sample: the old register value applies to that edge's computation.

Decomposition:
- A shared package holds the settings address constants (MUX_ADDR, OFS0_ADDR, OFS1_ADDR), the mux source encodings, and the 16-bit saturating subtract function.
- One natural sub-module, rx_dc_offset, instanced per channel. It covers the settings register, extend, subtract and saturate.
- The mux and RSSI logic stay in the top module.

Test Plan:
- Reset, then mux=0, rx_a_a=12'h100, offsets 0 → ddc0_in_i=16'h1000 and ddc0_in_q=16'h1000 exactly 3 cycles after the input; rx_numchan=0.
- Write OFS0_ADDR=16'h0800 with A=12'h100 → ddc0_in_i=16'h0800 and ddc0_in_q=16'h0800.
- Saturation cases:
  - A=12'h800 (ext 0x8000), offset 0x0010 → ddc0_in_i=16'h8000.
  - A=12'h7FF, offset 16'hFFF0 → 16'h7FFF.
- Write mux=8'hD2, A=12'h001, B=12'h002 → rx_numchan=2, ddc0_in_i=16'h0020, ddc0_in_q=16'h0000.
- Hold A=12'h7FF for 5 enabled cycles → rssi_0[31:16]=5.
  - Then write OFS0_ADDR → rssi_0[31:16]=0.
  - Deassert enable mid-stream → ddc outputs 0 next cycle and rssi_0 frozen.
- Assert reset_n low asynchronously mid-stream, between clock edges → all outputs 0 immediately; the mux and offsets return to 0.
